// File: rtl/inf_send.sv
// NEC infrared transmitter: leader, 32 LSB-first bits (addr, ~addr, data, ~data), stop mark,
// then a gap to the frame period; repeat codes follow while repeat_req is held.
module inf_send #(
  parameter int T_UNIT       = 28000,
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 438,
  parameter int FRAME_UNITS  = 196
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  input  logic       repeat_req,
  output logic       busy,
  output logic       done,
  output logic       inf_env,
  output logic       inf_out
);

  localparam int UW = (T_UNIT > 1) ? $clog2(T_UNIT) : 1;
  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [UW-1:0] C_UNIT_LAST  = UW'(T_UNIT - 1);
  localparam logic [CW-1:0] C_CAR_LAST   = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] C_CAR_HIGH   = CW'(CARRIER_HIGH);
  localparam logic [7:0]    C_FRAME_LAST = 8'(FRAME_UNITS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE,
    S_STOP_MARK, S_REP_MARK, S_REP_SPACE, S_REP_STOP, S_GAP
  } state_t;

  state_t        r_state, w_nxt;
  logic [UW-1:0] r_unit_cnt;
  logic [CW-1:0] r_car_cnt, w_car_nxt;
  logic [4:0]    r_st_cnt, w_dur, r_bit_cnt;
  logic [7:0]    r_fr_cnt;
  logic [31:0]   r_shift;
  logic          w_wrap, w_st_end, w_nxt_mark, w_enter_mark, w_accept;

  always_comb begin
    w_wrap   = (r_unit_cnt == C_UNIT_LAST);
    w_accept = (r_state == S_IDLE) && start;
    case (r_state)
      S_LEAD_MARK, S_REP_MARK: w_dur = 5'd16;
      S_LEAD_SPACE:            w_dur = 5'd8;
      S_REP_SPACE:             w_dur = 5'd4;
      S_BIT_SPACE:             w_dur = r_shift[0] ? 5'd3 : 5'd1;
      default:                 w_dur = 5'd1;
    endcase
    w_st_end = w_wrap && (r_st_cnt == w_dur - 5'd1);

    w_nxt = r_state;
    case (r_state)
      S_IDLE:       if (start)    w_nxt = S_LEAD_MARK;
      S_LEAD_MARK:  if (w_st_end) w_nxt = S_LEAD_SPACE;
      S_LEAD_SPACE: if (w_st_end) w_nxt = S_BIT_MARK;
      S_BIT_MARK:   if (w_st_end) w_nxt = S_BIT_SPACE;
      S_BIT_SPACE:  if (w_st_end) w_nxt = (r_bit_cnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
      S_STOP_MARK:  if (w_st_end) w_nxt = S_GAP;
      S_REP_MARK:   if (w_st_end) w_nxt = S_REP_SPACE;
      S_REP_SPACE:  if (w_st_end) w_nxt = S_REP_STOP;
      S_REP_STOP:   if (w_st_end) w_nxt = S_GAP;
      S_GAP: begin
        // The frame period is measured leader-to-leader, so the gap absorbs the remainder.
        if (w_wrap && (r_fr_cnt == C_FRAME_LAST))
          w_nxt = repeat_req ? S_REP_MARK : S_IDLE;
      end
      default:      w_nxt = S_IDLE;
    endcase

    w_nxt_mark   = (w_nxt == S_LEAD_MARK) || (w_nxt == S_BIT_MARK) || (w_nxt == S_STOP_MARK) ||
                   (w_nxt == S_REP_MARK)  || (w_nxt == S_REP_STOP);
    w_enter_mark = w_nxt_mark && (w_nxt != r_state);
    w_car_nxt    = (r_car_cnt == C_CAR_LAST) ? '0 : r_car_cnt + 1'b1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_unit_cnt <= '0;
      r_car_cnt  <= '0;
      r_st_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_fr_cnt   <= '0;
      r_shift    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      inf_env    <= 1'b0;
      inf_out    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      busy    <= (w_nxt != S_IDLE);
      done    <= (r_state == S_GAP) && (w_nxt == S_IDLE);
      inf_env <= w_nxt_mark;
      // Every mark restarts the carrier so it opens on a high phase.
      inf_out   <= w_nxt_mark && (w_enter_mark ? (C_CAR_HIGH != '0) : (w_car_nxt < C_CAR_HIGH));
      r_car_cnt <= (w_nxt_mark && !w_enter_mark) ? w_car_nxt : '0;

      r_unit_cnt <= ((r_state == S_IDLE) || w_wrap) ? '0 : r_unit_cnt + 1'b1;
      if (w_nxt != r_state)
        r_st_cnt <= '0;
      else if (w_wrap)
        r_st_cnt <= r_st_cnt + 5'd1;

      if (w_enter_mark && ((w_nxt == S_LEAD_MARK) || (w_nxt == S_REP_MARK)))
        r_fr_cnt <= '0;
      else if ((r_state != S_IDLE) && w_wrap)
        r_fr_cnt <= r_fr_cnt + 8'd1;

      if (w_accept) begin
        r_shift   <= {~data, data, ~addr, addr};
        r_bit_cnt <= '0;
      end else if ((r_state == S_BIT_SPACE) && w_st_end) begin
        r_shift   <= {1'b0, r_shift[31:1]};
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_inf_send.sv
// Directed bench for inf_send with a short unit (8 cycles) and carrier (1 of 4 high).
module tb_inf_send;
  localparam int PERIOD    = 1568;
  localparam int FRAME_CYC = 968;

  logic       sys_clk = 1'b0;
  logic       sys_rst, start, repeat_req;
  logic [7:0] addr, data;
  logic       busy, done, inf_env, inf_out;

  int checks = 0;
  int errors = 0;

  logic env_tr  [0:4999];
  logic out_tr  [0:4999];
  logic busy_tr [0:4999];
  logic done_tr [0:4999];
  int   exp_q[$];

  inf_send #(.T_UNIT(8), .CARRIER_DIV(4), .CARRIER_HIGH(1), .FRAME_UNITS(196)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .addr(addr), .data(data),
    .repeat_req(repeat_req), .busy(busy), .done(done), .inf_env(inf_env), .inf_out(inf_out)
  );

  always #5 sys_clk = ~sys_clk;

  // Expected envelope run lengths (alternating high/low) for one data frame plus its gap.
  task automatic push_frame(input logic [7:0] a, input logic [7:0] d);
    logic [31:0] w;
    w = {~d, d, ~a, a};
    exp_q.push_back(128);
    exp_q.push_back(64);
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(8);
      exp_q.push_back(w[i] ? 24 : 8);
    end
    exp_q.push_back(8);
    exp_q.push_back(PERIOD - FRAME_CYC);
  endtask

  task automatic push_rep();
    exp_q.push_back(128);
    exp_q.push_back(32);
    exp_q.push_back(8);
    exp_q.push_back(PERIOD - 168);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge (sample index 0).
  task automatic start_frame(input logic [7:0] a, input logic [7:0] d, input logic rep);
    start = 1'b1; addr = a; data = d; repeat_req = rep;
    @(posedge sys_clk);
    @(negedge sys_clk);
    start = 1'b0; addr = ~a; data = ~d;
  endtask

  task automatic capture(input int n, input int p1, input int p2, input int p3, input int drop_at);
    for (int k = 0; k <= n; k++) begin
      env_tr[k] = inf_env; out_tr[k] = inf_out; busy_tr[k] = busy; done_tr[k] = done;
      start = (k == p1) || (k == p2) || (k == p3);
      if (start) begin addr = 8'hA5; data = 8'h3C; end
      if (k == drop_at) repeat_req = 1'b0;
      if (k < n) @(negedge sys_clk);
    end
    start = 1'b0;
  endtask

  task automatic check_trace(input int n_end, input string name);
    int   runs[$];
    int   len, pos, bad_car, bad_bsy, nchk;
    logic cur, exp_out;
    checks++;
    if (env_tr[0] !== 1'b1) begin
      errors++; $display("FAIL %s first_env got %b expected 1", name, env_tr[0]);
    end
    cur = env_tr[0]; len = 0;
    for (int k = 0; k < n_end; k++) begin
      if (env_tr[k] === cur) len++;
      else begin runs.push_back(len); cur = env_tr[k]; len = 1; end
    end
    runs.push_back(len);
    checks++;
    if (runs.size() != exp_q.size()) begin
      errors++; $display("FAIL %s run_count got %0d expected %0d", name, runs.size(), exp_q.size());
    end
    nchk = (runs.size() < exp_q.size()) ? runs.size() : exp_q.size();
    for (int i = 0; i < nchk; i++) begin
      checks++;
      if (runs[i] != exp_q[i]) begin
        errors++; $display("FAIL %s run[%0d] got %0d expected %0d", name, i, runs[i], exp_q[i]);
      end
    end
    bad_car = 0; bad_bsy = 0; pos = 0;
    for (int k = 0; k < n_end; k++) begin
      if (env_tr[k] === 1'b1 && (k == 0 || env_tr[k-1] !== 1'b1)) pos = 0;
      else if (env_tr[k] === 1'b1) pos++;
      exp_out = (env_tr[k] === 1'b1) && (pos % 4 == 0);
      if (out_tr[k] !== exp_out) bad_car++;
      if (busy_tr[k] !== 1'b1 || done_tr[k] !== 1'b0) bad_bsy++;
    end
    checks++;
    if (bad_car != 0) begin
      errors++; $display("FAIL %s carrier bad_cycles got %0d expected 0", name, bad_car);
    end
    checks++;
    if (bad_bsy != 0) begin
      errors++; $display("FAIL %s busy_done_in_frame bad_cycles got %0d expected 0", name, bad_bsy);
    end
    checks++;
    if ({done_tr[n_end], busy_tr[n_end], env_tr[n_end]} !== 3'b100) begin
      errors++;
      $display("FAIL %s end done/busy/env got %b%b%b expected 100", name,
               done_tr[n_end], busy_tr[n_end], env_tr[n_end]);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; start = 1'b0; addr = 8'h00; data = 8'h00; repeat_req = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL rst_done got %b expected 0", done); end
    checks++; if (inf_env !== 1'b0) begin errors++; $display("FAIL rst_env got %b expected 0", inf_env); end
    checks++; if (inf_out !== 1'b0) begin errors++; $display("FAIL rst_out got %b expected 0", inf_out); end
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    start_frame(8'h12, 8'h34, 1'b0);
    repeat (150) @(negedge sys_clk);
    checks++;
    if ({busy, inf_env} !== 2'b10) begin
      errors++; $display("FAIL lead_space busy/env got %b%b expected 10", busy, inf_env);
    end
    #2 sys_rst = 1'b1;
    #1;
    checks++;
    if ({busy, inf_env, inf_out} !== 3'b000) begin
      errors++; $display("FAIL async_rst busy/env/out got %b%b%b expected 000", busy, inf_env, inf_out);
    end
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (20) @(negedge sys_clk);
    checks++;
    if ({busy, inf_env} !== 2'b00) begin
      errors++; $display("FAIL post_rst_idle busy/env got %b%b expected 00", busy, inf_env);
    end
    exp_q.delete();
    push_frame(8'h12, 8'h34);
    start_frame(8'h12, 8'h34, 1'b0);
    capture(PERIOD, -1, -1, -1, -1);
    check_trace(PERIOD, "reset_fresh");
  endtask

  task automatic test_basic();
    repeat (2) @(negedge sys_clk);
    exp_q.delete();
    push_frame(8'h00, 8'h45);
    start_frame(8'h00, 8'h45, 1'b0);
    capture(PERIOD, -1, -1, -1, -1);
    check_trace(PERIOD, "basic_00_45");
  endtask

  task automatic test_ignore_start();
    repeat (2) @(negedge sys_clk);
    exp_q.delete();
    push_frame(8'h5A, 8'hC3);
    start_frame(8'h5A, 8'hC3, 1'b0);
    capture(PERIOD, 50, 900, PERIOD - 1, -1);
    check_trace(PERIOD, "ignore_start");
    @(negedge sys_clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL gap_start_ignored busy got %b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    push_frame(8'h81, 8'h7E);
    start_frame(8'h81, 8'h7E, 1'b0);
    capture(PERIOD, -1, -1, -1, -1);
    check_trace(PERIOD, "after_done");
  endtask

  task automatic test_repeat();
    repeat (2) @(negedge sys_clk);
    exp_q.delete();
    push_frame(8'h00, 8'h45);
    push_rep();
    push_rep();
    start_frame(8'h00, 8'h45, 1'b1);
    capture(3 * PERIOD, -1, -1, -1, 2 * PERIOD + 64);
    check_trace(3 * PERIOD, "repeat");
  endtask

  task automatic test_all_ones();
    repeat (2) @(negedge sys_clk);
    exp_q.delete();
    push_frame(8'hFF, 8'hFF);
    start_frame(8'hFF, 8'hFF, 1'b0);
    capture(PERIOD, -1, -1, -1, -1);
    check_trace(PERIOD, "ff_ff");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_repeat();
    test_all_ones();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
